// File: rtl/bdi_pkg.sv
// Shared definitions for the bit-deinterleaver SRAM controller.
//   state_t    : controller FSM encoding (IDLE / WRITE / READ)
//   A_WID_DEF  : default SRAM address width
//   D_WID_DEF  : default soft-bit width
//   frame_len(): number of soft bits in one frame (ROWS*COLS)
package bdi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int A_WID_DEF = 18;
    localparam int D_WID_DEF = 6;

    function automatic int frame_len(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/bdi_out_buf.sv
// Two-entry output FIFO sitting behind the SRAM read port.
//   CLK, RST       : clock, synchronous active-high reset
//   push/push_data : write one entry (caller guarantees room)
//   pop            : drop the head entry (caller guarantees occ != 0)
//   occ            : current number of entries (0..2)
//   head           : oldest entry; reads 0 after reset
module bdi_out_buf
    import bdi_pkg::*;
#(
    parameter int D_WID = D_WID_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [D_WID-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [D_WID-1:0] head
);

    logic [1:0][D_WID-1:0] mem;
    logic                  wptr, rptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem  <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            // push and pop together leave occupancy unchanged
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/bdi_sram_ctrl.sv
// Frame SRAM initiator for the bit deinterleaver.
// Writes one frame of ROWS*COLS soft bits in arrival (row-major) order, then
// reads it back column-major into a 2-entry buffer and streams it out.
//   CLK, RST              : clock, synchronous active-high reset
//   in_valid/in_ready     : soft-bit input handshake, in_data payload
//   out_valid/out_ready   : deinterleaved output handshake, out_data payload
//   frame_done            : pulse with acceptance of the last output of a frame
//   mem_a/cen/wen/d, mem_q: single-port SRAM, active-low strobes, 1-cycle read
module bdi_sram_ctrl
    import bdi_pkg::*;
#(
    parameter int ROWS  = 360,
    parameter int COLS  = 408,
    parameter int A_WID = A_WID_DEF,
    parameter int D_WID = D_WID_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_WID-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_WID-1:0] out_data,
    output logic             frame_done,
    output logic [A_WID-1:0] mem_a,
    output logic             mem_cen,
    output logic             mem_wen,
    output logic [D_WID-1:0] mem_d,
    input  logic [D_WID-1:0] mem_q
);

    localparam int               FLEN     = frame_len(ROWS, COLS);
    localparam logic [A_WID-1:0] LAST_WR  = A_WID'(FLEN - 1);
    localparam logic [A_WID-1:0] ROW_LAST = A_WID'(ROWS - 1);
    localparam logic [A_WID-1:0] COLS_C   = A_WID'(COLS);
    localparam logic [A_WID-1:0] A_ONE    = 1;
    localparam logic [A_WID:0]   FLEN_C   = (A_WID+1)'(FLEN);
    localparam logic [A_WID:0]   LAST_OUT = (A_WID+1)'(FLEN - 1);
    localparam logic [A_WID:0]   C_ONE    = 1;

    state_t           state, state_nxt;
    logic [A_WID-1:0] wr_addr, rd_addr, row, col;
    logic [A_WID:0]   rd_cnt, out_cnt;
    logic             rd_pend;    // read strobed last cycle, data on mem_q now
    logic             wr_go, rd_go, pop;
    logic [1:0]       occ;
    logic [2:0]       credit;

    bdi_out_buf #(.D_WID(D_WID)) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_pend),
        .push_data (mem_q),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

    assign in_ready   = (state == WRITE);
    assign out_valid  = (occ != 2'd0);
    assign pop        = out_valid & out_ready;
    assign frame_done = pop & (out_cnt == LAST_OUT);

    // Slots the buffer will still hold after this cycle. Counting the pop
    // lets a new read go out every cycle while out_ready stays high.
    assign credit = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};

    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_a     = '0;
        mem_d     = '0;
        unique case (state)
            IDLE: state_nxt = WRITE;
            WRITE: begin
                wr_go = in_valid;
                if (in_valid) begin
                    mem_cen = 1'b0;
                    mem_wen = 1'b0;
                    mem_a   = wr_addr;
                    mem_d   = in_data;
                    if (wr_addr == LAST_WR)
                        state_nxt = READ;
                end
            end
            READ: begin
                rd_go = (rd_cnt != FLEN_C) && (credit < 3'd2);
                if (rd_go) begin
                    mem_cen = 1'b0;
                    mem_a   = rd_addr;
                end
                if (frame_done)
                    state_nxt = WRITE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            wr_addr <= '0;
            rd_addr <= '0;
            row     <= '0;
            col     <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_go;
            if (wr_go)
                wr_addr <= (wr_addr == LAST_WR) ? '0 : wr_addr + A_ONE;
            // column-major walk: step down a column by COLS, restart at the
            // top of the next column once the last row is read
            if (rd_go) begin
                rd_cnt <= rd_cnt + C_ONE;
                if (row == ROW_LAST) begin
                    row     <= '0;
                    col     <= col + A_ONE;
                    rd_addr <= col + A_ONE;
                end else begin
                    row     <= row + A_ONE;
                    rd_addr <= rd_addr + COLS_C;
                end
            end
            if (pop)
                out_cnt <= out_cnt + C_ONE;
            if (frame_done) begin
                rd_addr <= '0;
                row     <= '0;
                col     <= '0;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bdi_sram_ctrl.sv
// Directed bench: a 3x4 instance for ordering/handshake cases and a 36x40
// instance for a larger frame, each with a behavioural 1-cycle-read SRAM.
module tb_bdi_sram_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int nchk = 0;
    int nfail = 0;

    // ---------------- small instance: 3 rows x 4 cols ----------------
    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_frame_done;
    logic [5:0]  s_in_data = '0, s_out_data, s_mem_d, s_mem_q;
    logic [17:0] s_mem_a;
    logic        s_mem_cen, s_mem_wen;
    logic [5:0]  s_ram [16];

    bdi_sram_ctrl #(.ROWS(3), .COLS(4)) u_small (
        .CLK(CLK), .RST(RST),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .frame_done(s_frame_done),
        .mem_a(s_mem_a), .mem_cen(s_mem_cen), .mem_wen(s_mem_wen),
        .mem_d(s_mem_d), .mem_q(s_mem_q)
    );

    always @(posedge CLK)
        if (!s_mem_cen) begin
            if (!s_mem_wen) s_ram[s_mem_a[3:0]] <= s_mem_d;
            else            s_mem_q <= s_ram[s_mem_a[3:0]];
        end

    int s_q[$];
    int s_fd = 0, s_rds = 0, s_pops = 0, s_max_os = 0, s_max_ra = 0, s_max_wa = 0;
    int s_irdy_err = 0, s_strobe_err = 0;

    // mid-cycle monitor: inputs are stable here until the next rising edge
    always @(negedge CLK) begin
        if (RST) begin
            s_rds  = 0;
            s_pops = 0;
        end else begin
            if (s_out_valid && s_out_ready) begin
                s_q.push_back(int'(s_out_data));
                s_pops++;
            end
            if (s_frame_done) s_fd++;
            if (!s_mem_cen && s_mem_wen) begin
                s_rds++;
                if (int'(s_mem_a) > s_max_ra) s_max_ra = int'(s_mem_a);
            end
            if (!s_mem_cen && !s_mem_wen) begin
                if (int'(s_mem_a) > s_max_wa) s_max_wa = int'(s_mem_a);
                if (!(s_in_valid && s_in_ready)) s_strobe_err++;
            end
            if (s_in_ready && (s_out_valid || (!s_mem_cen && s_mem_wen))) s_irdy_err++;
            if (s_rds - s_pops > s_max_os) s_max_os = s_rds - s_pops;
        end
    end

    // ---------------- larger instance: 36 rows x 40 cols ----------------
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_frame_done;
    logic [5:0]  b_in_data = '0, b_out_data, b_mem_d, b_mem_q;
    logic [17:0] b_mem_a;
    logic        b_mem_cen, b_mem_wen;
    logic [5:0]  b_ram [2048];

    bdi_sram_ctrl #(.ROWS(36), .COLS(40)) u_big (
        .CLK(CLK), .RST(RST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .frame_done(b_frame_done),
        .mem_a(b_mem_a), .mem_cen(b_mem_cen), .mem_wen(b_mem_wen),
        .mem_d(b_mem_d), .mem_q(b_mem_q)
    );

    always @(posedge CLK)
        if (!b_mem_cen) begin
            if (!b_mem_wen) b_ram[b_mem_a[10:0]] <= b_mem_d;
            else            b_mem_q <= b_ram[b_mem_a[10:0]];
        end

    int b_q[$];
    int b_fd = 0, b_max_ra = 0, b_max_wa = 0;

    always @(negedge CLK)
        if (!RST) begin
            if (b_out_valid && b_out_ready) b_q.push_back(int'(b_out_data));
            if (b_frame_done) b_fd++;
            if (!b_mem_cen && int'(b_mem_a) > b_max_ra && b_mem_wen)  b_max_ra = int'(b_mem_a);
            if (!b_mem_cen && int'(b_mem_a) > b_max_wa && !b_mem_wen) b_max_wa = int'(b_mem_a);
        end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // column-major order of consecutive 3x4 frames numbered from 0
    function automatic int exp_small(input int k);
        int f, j;
        f = k / 12;
        j = k % 12;
        return f * 12 + (j % 3) * 4 + j / 3;
    endfunction

    // feed nin inputs (base, base+1, ...) while draining until nout outputs
    task automatic run(input int nin, input int base, input bit gaps, input bit rpat, input int nout);
        fork
            begin
                int  i;
                bit  acc;
                i = 0;
                for (int cyc = 0; cyc < 2000 && i < nin; cyc++) begin
                    s_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    s_in_data  = 6'(base + i);
                    #1;
                    acc = s_in_valid && s_in_ready;
                    @(posedge CLK); #1;
                    if (acc) i++;
                end
                s_in_valid = 1'b0;
                chk("inputs_accepted", 32'(i), 32'(nin));
            end
            begin
                for (int cyc = 0; cyc < 2000 && s_q.size() < nout; cyc++) begin
                    s_out_ready = rpat ? (cyc % 3 == 0) : 1'b1;
                    @(posedge CLK); #1;
                end
                s_out_ready = 1'b0;
            end
        join
    endtask

    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_count"}, 32'(s_q.size()), 32'(n));
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_out%0d", tag, k), (k < s_q.size()) ? 32'(s_q[k]) : 32'hFFFF_FFFF,
                32'(exp_small(k)));
    endtask

    initial begin
        int fd0, bi, mism;
        bit acc;

        // 1: reset held for 3 cycles
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk("rst_in_ready",   32'(s_in_ready), 0);
            chk("rst_out_valid",  32'(s_out_valid), 0);
            chk("rst_out_data",   32'(s_out_data), 0);
            chk("rst_frame_done", 32'(s_frame_done), 0);
            chk("rst_mem_cen",    32'(s_mem_cen), 1);
            chk("rst_mem_wen",    32'(s_mem_wen), 1);
            chk("rst_mem_a",      32'(s_mem_a), 0);
            chk("rst_mem_d",      32'(s_mem_d), 0);
            chk("rst_big_cen",    32'(b_mem_cen), 1);
        end
        RST = 1'b0;
        #1;
        chk("idle_in_ready", 32'(s_in_ready), 0);
        @(posedge CLK); #1;
        chk("write_in_ready", 32'(s_in_ready), 1);

        // 2: one frame, in_valid and out_ready held
        s_q.delete();
        run(12, 0, 1'b0, 1'b0, 12);
        chk_seq("t2", 12);
        chk("t2_frame_done", 32'(s_fd), 1);
        chk("t2_max_rd_addr", 32'(s_max_ra), 11);
        chk("t2_max_wr_addr", 32'(s_max_wa), 11);
        chk("t2_in_ready_after", 32'(s_in_ready), 1);

        // 3: input gaps and a 1,0,0 out_ready pattern
        s_q.delete();
        run(12, 0, 1'b1, 1'b1, 12);
        chk_seq("t3", 12);
        chk("t3_frame_done", 32'(s_fd), 2);
        chk("t3_max_outstanding_le2", 32'(s_max_os <= 2), 1);

        // 4: two frames back to back, second frame 12..23
        s_q.delete();
        run(24, 0, 1'b0, 1'b0, 24);
        chk_seq("t4", 24);
        chk("t4_frame_done", 32'(s_fd), 4);
        chk("t4_in_ready_in_read", 32'(s_irdy_err), 0);
        chk("t4_max_outstanding", 32'(s_max_os), 2);

        // 5: reset after 5 outputs of a frame, then a fresh frame
        s_q.delete();
        fd0 = s_fd;
        run(12, 0, 1'b0, 1'b0, 5);
        chk_seq("t5a", 5);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("t5_rst_out_valid", 32'(s_out_valid), 0);
        chk("t5_rst_mem_cen",   32'(s_mem_cen), 1);
        RST = 1'b0;
        s_q.delete();
        run(12, 0, 1'b0, 1'b0, 12);
        chk_seq("t5b", 12);
        chk("t5_frame_done", 32'(s_fd - fd0), 1);
        chk("strobe_without_accept", 32'(s_strobe_err), 0);

        // 6: 36x40 frame of (i mod 64)
        bi = 0;
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 6000 && b_q.size() < 1440; cyc++) begin
            b_in_valid = (bi < 1440);
            b_in_data  = 6'(bi % 64);
            #1;
            acc = b_in_valid && b_in_ready;
            @(posedge CLK); #1;
            if (acc) bi++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        mism = 0;
        for (int k = 0; k < b_q.size(); k++)
            if (b_q[k] != (((k % 36) * 40 + k / 36) % 64)) mism++;
        chk("t6_count", 32'(b_q.size()), 1440);
        chk("t6_order_mismatches", 32'(mism), 0);
        chk("t6_max_rd_addr", 32'(b_max_ra), 1439);
        chk("t6_max_wr_addr", 32'(b_max_wa), 1439);
        chk("t6_frame_done", 32'(b_fd), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
